mix_add_round_stage: RTL and testbench
======================================

MIX_ADD_ROUND_STAGE -- requirements
Module: mix_add_round_stage

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on its rising edge.
REQ-002 SHALL have ports: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have ports: in_valid  input  1  upstream block valid.
REQ-004 SHALL have ports: in_ready  output  1  stage can accept a block.
REQ-005 SHALL have ports: in_state  input  128  block from the row-shift stage; byte (row r, col c) at bits [127-32c-8r -: 8].
REQ-006 SHALL have ports: in_key  input  128  round key, same byte layout.
REQ-007 SHALL have ports: in_last  input  1  final round: MixColumns bypassed.
REQ-008 SHALL have ports: in_inv  input  1  inverse MixColumns select; present only with AES_INV_MIXCOL_EN.
REQ-009 SHALL have ports: out_valid  output  1  result valid.
REQ-010 SHALL have ports: out_ready  input  1  downstream accepts.
REQ-011 SHALL have ports: out_state  output  128  round result.
REQ-012 SHALL have ports: busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; accept on in_valid&&in_ready by registering in_state, in_key, in_last, in_inv, clearing col counter to 0, going to CALC.
REQ-015 SHALL process one 32-bit column per CALC cycle, col 0..3: result_col = MixColumns(col) XOR key_col, or col XOR key_col when last=1.
REQ-016 SHALL use a 2-bit column counter; at col=3, counter wraps to 0 and FSM goes to DONE.
REQ-017 SHALL have fixed latency: out_valid first high in the cycle after the 4th rising edge following the accepting edge.
REQ-018 SHALL hold out_valid=1 and out_state stable in DONE until out_valid&&out_ready, then go to IDLE.
REQ-019 SHALL not accept a new block in CALC or DONE; in_valid there is ignored and upstream data is not consumed.
REQ-020 SHALL compute GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1; xtime(b)={b[6:0],0} XOR (b[7] ? 8'h1B : 0).
REQ-021 SHALL use forward coefficients (02,03,01,01), circulant.
REQ-022 SHALL use inverse coefficients (0E,0B,0D,09) when in_inv=1.
REQ-023 SHALL make out_state a registered output, never combinationally dependent on inputs.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, force IDLE, col=0, out_valid=0, out_state=0, busy=0, regardless of current state (mid-CALC or DONE: block discarded).
REQ-025 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-026 SHALL compile the in_inv port and inverse MixColumns datapath only when macro AES_INV_MIXCOL_EN is defined.
REQ-027 SHALL, when AES_INV_MIXCOL_EN is undefined, omit the in_inv port and perform only the forward transform.

Structure
REQ-028 SHALL place state_t (128-bit), col_t (32-bit), the FSM enum, constant AES_POLY=8'h1B and function xtime in shared package aes_pkg.
REQ-029 SHALL implement the per-column transform as combinational sub-module mix_column (32-bit in, inv select, 32-bit out), instantiated once and time-shared over columns.

Verification
REQ-030 SHALL cover the forward round: in_state={db135345,f20a225c,01010101,c6c6c6c6}, key=0, last=0 -> out_state={8e4da1bc,9fdc589d,01010101,c6c6c6c6} after the latency in REQ-017.
REQ-031 SHALL cover the final round: last=1, key=all-FF, any in_state X -> out_state=~X; MixColumns bypassed.
REQ-032 SHALL cover backpressure: out_ready=0 for 10 cycles in DONE -> out_valid=1, out_state constant, in_ready=0, second in_valid not consumed.
REQ-033 SHALL cover reset mid-operation: rst pulsed during CALC col=2 -> next cycle out_valid=0, out_state=0, in_ready=1, no result emitted.
REQ-034 SHALL cover the inverse round (AES_INV_MIXCOL_EN): feed {8e4da1bc,9fdc589d,01010101,c6c6c6c6}, key=0, inv=1 -> {db135345,f20a225c,01010101,c6c6c6c6}.
REQ-035 SHALL cover back-to-back traffic: in_valid held high with out_ready=1 -> one block accepted every 6 cycles, results in order.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES round types, FSM encoding and GF(2^8) helpers.
// No logic of its own; imported by the mix/add-round datapath.
// Column c of a state occupies bits [127-32c -: 32], row r of a column bits [31-8r -: 8].
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  col_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam logic [7:0] AES_POLY = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic col_t get_col(input state_t s, input logic [1:0] c);
        col_t r;
        case (c)
            2'd0:    r = s[127:96];
            2'd1:    r = s[95:64];
            2'd2:    r = s[63:32];
            default: r = s[31:0];
        endcase
        return r;
    endfunction

    function automatic state_t set_col(input state_t s, input logic [1:0] c, input col_t v);
        state_t r;
        r = s;
        case (c)
            2'd0:    r[127:96] = v;
            2'd1:    r[95:64]  = v;
            2'd2:    r[63:32]  = v;
            default: r[31:0]   = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mix_column.sv
// MixColumns on one 32-bit column (forward, or inverse when AES_INV_MIXCOL_EN is defined).
// Latency: purely combinational.
// Backpressure: none; the caller holds the input stable.
module mix_column
    import aes_pkg::*;
(
    input  col_t col_i,
`ifdef AES_INV_MIXCOL_EN
    input  logic inv_i,
`endif
    output col_t col_o
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] t0, t1, t2, t3;
    col_t       fwd;

    assign {a0, a1, a2, a3} = col_i;

    assign t0 = xtime(a0);
    assign t1 = xtime(a1);
    assign t2 = xtime(a2);
    assign t3 = xtime(a3);

    // 03*x is xtime(x)^x, so each row is t(r) ^ t(r+1) ^ the three bytes other than a(r)
    assign fwd = {t0 ^ t1 ^ a1 ^ a2 ^ a3,
                  t1 ^ t2 ^ a2 ^ a3 ^ a0,
                  t2 ^ t3 ^ a3 ^ a0 ^ a1,
                  t3 ^ t0 ^ a0 ^ a1 ^ a2};

`ifdef AES_INV_MIXCOL_EN
    logic [7:0] q0, q1, q2, q3;
    logic [7:0] o0, o1, o2, o3;
    logic [7:0] m9_0, m9_1, m9_2, m9_3;
    logic [7:0] mb_0, mb_1, mb_2, mb_3;
    logic [7:0] md_0, md_1, md_2, md_3;
    logic [7:0] me_0, me_1, me_2, me_3;
    col_t       inv;

    assign q0 = xtime(t0);
    assign q1 = xtime(t1);
    assign q2 = xtime(t2);
    assign q3 = xtime(t3);
    assign o0 = xtime(q0);
    assign o1 = xtime(q1);
    assign o2 = xtime(q2);
    assign o3 = xtime(q3);

    assign m9_0 = o0 ^ a0;       assign m9_1 = o1 ^ a1;
    assign m9_2 = o2 ^ a2;       assign m9_3 = o3 ^ a3;
    assign mb_0 = o0 ^ t0 ^ a0;  assign mb_1 = o1 ^ t1 ^ a1;
    assign mb_2 = o2 ^ t2 ^ a2;  assign mb_3 = o3 ^ t3 ^ a3;
    assign md_0 = o0 ^ q0 ^ a0;  assign md_1 = o1 ^ q1 ^ a1;
    assign md_2 = o2 ^ q2 ^ a2;  assign md_3 = o3 ^ q3 ^ a3;
    assign me_0 = o0 ^ q0 ^ t0;  assign me_1 = o1 ^ q1 ^ t1;
    assign me_2 = o2 ^ q2 ^ t2;  assign me_3 = o3 ^ q3 ^ t3;

    assign inv = {me_0 ^ mb_1 ^ md_2 ^ m9_3,
                  me_1 ^ mb_2 ^ md_3 ^ m9_0,
                  me_2 ^ mb_3 ^ md_0 ^ m9_1,
                  me_3 ^ mb_0 ^ md_1 ^ m9_2};

    assign col_o = inv_i ? inv : fwd;
`else
    assign col_o = fwd;
`endif

endmodule

// File: rtl/mix_add_round_stage.sv
// AES MixColumns + AddRoundKey stage, one column per cycle; inverse mode with AES_INV_MIXCOL_EN.
// Latency: result valid the cycle after the 4th edge following acceptance; one block per 6 cycles max.
// Backpressure: single block in flight; in_ready only in IDLE, result held in DONE until out_ready.
module mix_add_round_stage
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    input  logic         in_last,
`ifdef AES_INV_MIXCOL_EN
    input  logic         in_inv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    fsm_t       state_q, state_d;
    logic [1:0] col_q, col_d;
    state_t     blk_q, blk_d;
    state_t     key_q, key_d;
    state_t     res_q, res_d;
    logic       last_q, last_d;
    logic       out_valid_q, out_valid_d;
`ifdef AES_INV_MIXCOL_EN
    logic       inv_q, inv_d;
`endif

    col_t cur_col;
    col_t key_col;
    col_t mixed_col;
    col_t res_col;

    assign cur_col = get_col(blk_q, col_q);
    assign key_col = get_col(key_q, col_q);

    mix_column u_mix_column (
        .col_i (cur_col),
`ifdef AES_INV_MIXCOL_EN
        .inv_i (inv_q),
`endif
        .col_o (mixed_col)
    );

    // final round skips MixColumns and only adds the key
    assign res_col = (last_q ? cur_col : mixed_col) ^ key_col;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        blk_d       = blk_q;
        key_d       = key_q;
        res_d       = res_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
`ifdef AES_INV_MIXCOL_EN
        inv_d       = inv_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    blk_d   = in_state;
                    key_d   = in_key;
                    last_d  = in_last;
`ifdef AES_INV_MIXCOL_EN
                    inv_d   = in_inv;
`endif
                    col_d   = 2'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                res_d = set_col(res_q, col_q, res_col);
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                col_d       = 2'd0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= 2'd0;
            blk_q       <= '0;
            key_q       <= '0;
            res_q       <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef AES_INV_MIXCOL_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            blk_q       <= blk_d;
            key_q       <= key_d;
            res_q       <= res_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
`ifdef AES_INV_MIXCOL_EN
            inv_q       <= inv_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_state = res_q;

    // a stalled result must not move
    a_hold_done: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_state)));

    a_valid_only_done: assert property (@(posedge clk) disable iff (rst)
        out_valid == (state_q == DONE));

endmodule

// File: tb/tb_mix_add_round_stage.sv
// Bench for mix_add_round_stage: vector table + scoreboard, plus backpressure, reset and streaming sequences.
// Inverse vectors are included when AES_INV_MIXCOL_EN is defined.
module tb_mix_add_round_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         in_last;
`ifdef AES_INV_MIXCOL_EN
    logic         in_inv;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    typedef struct {
        logic [127:0] st;
        logic [127:0] key;
        logic         last;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    vec_t         vecs[$];
    logic [127:0] sb[$];
    logic [127:0] drv_exp;
    int           vec_cnt = 0;
    int           err_cnt = 0;
    int           cyc = 0;

    mix_add_round_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_last   (in_last),
`ifdef AES_INV_MIXCOL_EN
        .in_inv    (in_inv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] model_col(input logic [31:0] c, input logic inv);
        logic [7:0]  a[4];
        logic [7:0]  cf[4];
        logic [31:0] res;
        logic [7:0]  s;
        if (inv) begin
            cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
        end else begin
            cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
        end
        for (int r = 0; r < 4; r++) a[r] = c[31-8*r -: 8];
        res = '0;
        for (int r = 0; r < 4; r++) begin
            s = 8'h00;
            for (int j = 0; j < 4; j++) s = s ^ gmul(cf[2'(j - r)], a[2'(j)]);
            res[31-8*r -: 8] = s;
        end
        return res;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] key,
                                           input logic last, input logic inv);
        logic [127:0] res;
        logic [31:0]  c;
        res = '0;
        for (int k = 0; k < 4; k++) begin
            c = st[127-32*k -: 32];
            res[127-32*k -: 32] = (last ? c : model_col(c, inv)) ^ key[127-32*k -: 32];
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [127:0] st, input logic [127:0] key, input logic last,
                           input logic inv, input logic [127:0] exp);
        vec_t v;
        v.st = st; v.key = key; v.last = last; v.inv = inv; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        in_state = v.st;
        in_key   = v.key;
        in_last  = v.last;
`ifdef AES_INV_MIXCOL_EN
        in_inv   = v.inv;
`endif
        drv_exp  = v.exp;
        in_valid = 1'b1;
    endtask

    // leaves the caller at a negedge where in_ready is high (or the bound expired)
    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drain", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready) sb.push_back(drv_exp);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected_output: got %h, expected no result", out_state);
                end else begin
                    chk("scoreboard", out_state, sb.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   acc[4];
        logic saw;
        vec_t bp0, bp1;

        add_vec(128'hdb135345_f20a225c_01010101_c6c6c6c6, '0, 1'b0, 1'b0,
                128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
        add_vec(128'h01234567_89abcdef_fedcba98_76543210, {128{1'b1}}, 1'b1, 1'b0,
                128'hfedcba98_76543210_01234567_89abcdef);
        add_vec(128'h3243f6a8_885a308d_313198a2_e0370734, {128{1'b1}}, 1'b1, 1'b0,
                ~128'h3243f6a8_885a308d_313198a2_e0370734);
        add_vec(128'h00112233_44556677_8899aabb_ccddeeff, 128'h00010203_04050607_08090a0b_0c0d0e0f,
                1'b0, 1'b0, model(128'h00112233_44556677_8899aabb_ccddeeff,
                                  128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b0, 1'b0));
        add_vec('0, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 1'b0, 1'b0,
                128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
        add_vec({128{1'b1}}, '0, 1'b0, 1'b0, {128{1'b1}});
        add_vec(128'h80808080_01020304_fe7f1b36_a5a5a5a5, 128'hdeadbeef_00000000_12345678_ffffffff,
                1'b0, 1'b0, model(128'h80808080_01020304_fe7f1b36_a5a5a5a5,
                                  128'hdeadbeef_00000000_12345678_ffffffff, 1'b0, 1'b0));
`ifdef AES_INV_MIXCOL_EN
        add_vec(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, '0, 1'b0, 1'b1,
                128'hdb135345_f20a225c_01010101_c6c6c6c6);
        add_vec(128'h00112233_44556677_8899aabb_ccddeeff, 128'h0f0e0d0c_0b0a0908_07060504_03020100,
                1'b0, 1'b1, model(128'h00112233_44556677_8899aabb_ccddeeff,
                                  128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b0, 1'b1));
`endif

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_last = 1'b0;
        in_state = '0; in_key = '0; drv_exp = '0;
`ifdef AES_INV_MIXCOL_EN
        in_inv = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_state", out_state, 0);
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 1);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            wait_ready();
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 0;
            @(negedge clk);
            while (!out_valid && lat < 20) begin
                @(posedge clk); @(negedge clk);
                lat++;
            end
            chk("latency", lat, 4);
        end
        @(posedge clk); #1;
        wait_drain();

        // backpressure: result held 10 cycles while a second block waits upstream
        bp0 = vecs[3];
        bp1 = vecs[6];
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(bp0);
        wait_ready();
        @(posedge clk); #1;
        drive(bp1);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        for (int k = 0; k < 10; k++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_state", out_state, bp0.exp);
            chk("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain();

        // reset pulsed while column 2 is being processed
        @(posedge clk); #1;
        drive(vecs[0]);
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_state", out_state, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        chk("midrst_no_result", saw, 0);

        // back-to-back with in_valid held high
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            drive(vecs[i]);
            wait_ready();
            acc[i] = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) chk("b2b_spacing", acc[i] - acc[i-1], 6);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
